// File: rtl/mem_bus_pkg.sv
// Shared types and bus constants for the memory bus initiator.
// Command records are buffered whole, so the struct carries every field a read or write needs.
package mem_bus_pkg;

  localparam int unsigned MEM_ADDR_W = 5;
  localparam int unsigned MEM_DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StCapture,
    StResp
  } mbm_state_e;

  // 'expect' is a reserved word, hence expect_data.
  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  check;
    logic [MEM_DATA_W-1:0] expect_data;
  } mem_cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// Synchronous show-ahead FIFO of mem_cmd_t records; dout is the head entry whenever !empty.
// Push while full and pop while empty are ignored.
module mem_cmd_fifo
  import mem_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  input  mem_cmd_t din,
  output mem_cmd_t dout
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  mem_cmd_t        mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Memory bus initiator: buffers read/write commands and sequences them one at a time onto the
// bus, returning read data with optional expected-data checking and a saturating error count.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_check,
  input  logic [DATA_W-1:0] cmd_expect,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_mismatch,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic [15:0]       err_count
);

  mem_cmd_t          cmd_in;
  mem_cmd_t          cmd_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  mbm_state_e        state_q;
  logic              cur_check_q;
  logic [DATA_W-1:0] cur_expect_q;

  assign cmd_in = '{
    write:       cmd_write,
    addr:        cmd_addr,
    wdata:       cmd_wdata,
    check:       cmd_check,
    expect_data: cmd_expect
  };

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  mem_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .pop  (fifo_pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .din  (cmd_in),
    .dout (cmd_head)
  );

  // Strobes are raised on the transition into WRITE/READ so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cur_check_q  <= 1'b0;
      cur_expect_q <= '0;
      rsp_valid    <= 1'b0;
      rsp_addr     <= '0;
      rsp_rdata    <= '0;
      rsp_mismatch <= 1'b0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_addr     <= '0;
      mem_data_in  <= '0;
      err_count    <= '0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            mem_addr     <= cmd_head.addr;
            cur_check_q  <= cmd_head.check;
            cur_expect_q <= cmd_head.expect_data;
            if (cmd_head.write) begin
              mem_data_in <= cmd_head.wdata;
              mem_write   <= 1'b1;
              state_q     <= StWrite;
            end else begin
              mem_read <= 1'b1;
              state_q  <= StRead;
            end
          end
        end
        StWrite: state_q <= StIdle;
        StRead:  state_q <= StCapture;
        StCapture: begin
          rsp_addr     <= mem_addr;
          rsp_rdata    <= mem_data_out;
          rsp_mismatch <= cur_check_q && (mem_data_out != cur_expect_q);
          rsp_valid    <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_mismatch && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'd1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: a behavioural memory on the bus, a reference memory
// that predicts every bus operation and read response, and monitors that pop and compare.
module tb_mem_bus_master;
  import mem_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       cmd_check = 1'b0;
  logic [7:0] cmd_expect = '0;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic       rsp_mismatch;
  logic       mem_read;
  logic       mem_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_data_in;
  logic [7:0] mem_data_out;
  logic       busy;
  logic [15:0] err_count;

  mem_bus_master dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_check   (cmd_check),
    .cmd_expect  (cmd_expect),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .rsp_mismatch(rsp_mismatch),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .busy        (busy),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural memory on the bus: read data appears the cycle after mem_read.
  logic [7:0] bus_mem [32];
  bit init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) bus_mem[i] <= 8'h00;
      mem_data_out <= 8'h00;
      init_done    <= 1'b1;
    end else begin
      if (mem_write) bus_mem[mem_addr] <= mem_data_in;
      if (mem_read) mem_data_out <= bus_mem[mem_addr];
    end
  end

  // Reference model: memory contents as seen by commands in acceptance order.
  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       mis;
  } rsp_exp_t;
  typedef struct {
    logic       w;
    logic [4:0] addr;
    logic [7:0] data;
  } bus_exp_t;

  logic [7:0] ref_mem [32];
  rsp_exp_t   rsp_q[$];
  bus_exp_t   bus_q[$];
  logic [15:0] exp_err = '0;

  int rsp_mode = 1;  // 0: hold rsp_ready low, 1: high, 2: random
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares bus strobes and read responses against the predicted queues.
  int         last_wr_cyc = 0;
  int         last_rd_cyc = 0;
  bit         prev_strobe = 1'b0;
  bit         err_pend = 1'b0;
  bit         stall_pend = 1'b0;
  logic [4:0] st_addr;
  logic [7:0] st_data;
  bus_exp_t   be;
  rsp_exp_t   re;

  always @(negedge clk) begin
    if (!rst) begin
      prev_strobe = 1'b0;
      err_pend    = 1'b0;
      stall_pend  = 1'b0;
    end else begin
      if (err_pend) begin
        check("err_count", err_count, exp_err);
        err_pend = 1'b0;
      end
      if (stall_pend) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_addr", rsp_addr, st_addr);
        check("rsp_hold_rdata", rsp_rdata, st_data);
        stall_pend = 1'b0;
      end
      if (mem_read || mem_write) begin
        check("strobe_exclusive", mem_read && mem_write, 0);
        check("strobe_one_cycle", prev_strobe, 0);
        check("no_issue_while_rsp", rsp_valid, 0);
        check("bus_op_expected", bus_q.size() > 0, 1);
        if (bus_q.size() > 0) begin
          be = bus_q.pop_front();
          check("bus_kind", mem_write, be.w);
          check("bus_addr", mem_addr, be.addr);
          if (be.w) check("bus_wdata", mem_data_in, be.data);
        end
        if (mem_write) last_wr_cyc = cyc;
        else last_rd_cyc = cyc;
      end
      prev_strobe = mem_read || mem_write;
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          re = rsp_q.pop_front();
          check("rsp_addr", rsp_addr, re.addr);
          check("rsp_rdata", rsp_rdata, re.data);
          check("rsp_mismatch", rsp_mismatch, re.mis);
          if (re.mis && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        end
        err_pend = 1'b1;
      end else if (rsp_valid) begin
        stall_pend = 1'b1;
        st_addr    = rsp_addr;
        st_data    = rsp_rdata;
      end
    end
  end

  // Called and returns at posedge+1; hs is the cycle in which the handshake occurred.
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d,
                      input logic c, input logic [7:0] e, output int hs);
    bit acc = 1'b0;
    int guard = 0;
    cmd_valid  = 1'b1;
    cmd_write  = w;
    cmd_addr   = a;
    cmd_wdata  = d;
    cmd_check  = c;
    cmd_expect = e;
    hs = 0;
    while (!acc) begin
      @(negedge clk);
      acc = cmd_ready;
      hs  = cyc;
      @(posedge clk);
      if (acc) begin
        bus_q.push_back('{w: w, addr: a, data: d});
        if (w) ref_mem[a] = d;
        else rsp_q.push_back('{addr: a, data: ref_mem[a], mis: c && (ref_mem[a] != e)});
      end
      #1;
      guard++;
      if (!acc && guard > 2000) begin
        check("cmd_accept_in_time", guard <= 2000, 1);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((busy || rsp_q.size() != 0 || bus_q.size() != 0) && g < 3000);
    check("drain_busy", busy, 0);
    check("drain_queues", rsp_q.size() + bus_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    rsp_q.delete();
    bus_q.delete();
    exp_err = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_rsp", {rsp_valid, rsp_addr, rsp_rdata, rsp_mismatch}, 0);
    check("reset_mem", {mem_read, mem_write, mem_addr, mem_data_in}, 0);
    check("reset_err_count", err_count, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_busy", busy, 0);
    @(posedge clk);
    #1;
  endtask

  int hs;
  int g;
  logic [7:0] d0, d1;
  logic       w;
  logic [4:0] a;

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    do_reset();

    // Write then checked read of the same address, with latency measurement.
    send(1'b1, 5'd5, 8'h41, 1'b0, 8'h00, hs);
    wait_idle();
    check("write_strobe_latency", last_wr_cyc - hs, 2);
    send(1'b0, 5'd5, 8'h00, 1'b1, 8'h41, hs);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 50);
    check("rsp_valid_latency", cyc - hs, 4);
    check("t2_rdata", rsp_rdata, 8'h41);
    check("t2_mismatch", rsp_mismatch, 0);
    wait_idle();
    check("read_strobe_latency", last_rd_cyc - hs, 2);

    // Checked read with the wrong expectation.
    send(1'b0, 5'd5, 8'h00, 1'b1, 8'h42, hs);
    wait_idle();
    check("t3_mismatch", rsp_mismatch, 1);
    check("t3_err_count", err_count, 1);

    // Fill the buffer behind a stalled response.
    rsp_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send(1'b0, 5'(i), 8'h00, 1'b0, 8'h00, hs);
    @(negedge clk);
    check("t4_full_cmd_ready", cmd_ready, 0);
    check("t4_pending_ops", bus_q.size(), 4);
    repeat (3) @(negedge clk);
    check("t4_still_held", cmd_ready, 0);
    check("t4_no_issue", bus_q.size(), 4);
    @(posedge clk);
    #1;
    rsp_mode = 1;
    wait_idle();

    // Both ends of the address range.
    d0 = 8'($urandom);
    d1 = 8'($urandom);
    send(1'b1, 5'd31, d1, 1'b0, 8'h00, hs);
    send(1'b1, 5'd0, d0, 1'b0, 8'h00, hs);
    send(1'b0, 5'd31, 8'h00, 1'b1, d1, hs);
    send(1'b0, 5'd0, 8'h00, 1'b1, d0, hs);
    wait_idle();
    check("t5_err_unchanged", err_count, 1);

    // Reset in the middle of a read.
    send(1'b0, 5'd31, 8'h00, 1'b0, 8'h00, hs);
    @(negedge clk);
    check("pre_reset_busy", busy, 1);
    @(posedge clk);
    #1;
    do_reset();

    // Saturation: preload near the top, then force mismatches past it.
    force dut.err_count = 16'hFFFD;
    @(posedge clk);
    #1;
    release dut.err_count;
    exp_err = 16'hFFFD;
    @(negedge clk);
    check("sat_preload", err_count, 16'hFFFD);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      a = 5'($urandom_range(0, 31));
      send(1'b0, a, 8'h00, 1'b1, ~ref_mem[a], hs);
    end
    wait_idle();
    check("sat_err_count", err_count, 16'hFFFF);

    // Random traffic with random response back-pressure.
    rsp_mode = 2;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      w = 1'($urandom_range(0, 1));
      a = 5'($urandom_range(0, 31));
      d0 = ($urandom_range(0, 1) == 1) ? ref_mem[a] : 8'($urandom);
      send(w, a, 8'($urandom), 1'($urandom_range(0, 1)), d0, hs);
    end
    rsp_mode = 1;
    wait_idle();
    check("final_err_saturated", err_count, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
